// File: rtl/sam_pkg.sv
// Shared types and tables for the SAM video address counter.
// The divider tables are indexed by the VDG mode bits V2..V0.
package sam_pkg;

    localparam int ADDR_W = 16;
    localparam int OFF_W  = 7;

    typedef enum logic [2:0] {
        ALPHA = 3'd0,
        G1C   = 3'd1,
        G1R   = 3'd2,
        G2C   = 3'd3,
        G2R   = 3'd4,
        G3C   = 3'd5,
        G3R   = 3'd6,
        DMA   = 3'd7
    } sam_mode_e;

    // Tables hold divider-1, entries ordered mode 7 down to mode 0
    localparam logic [7:0][1:0] XDIV_M1 = {
        2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0
    };
    localparam logic [7:0][3:0] YDIV_M1 = {
        4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd11
    };

    function automatic logic [1:0] xdiv_m1(input sam_mode_e m);
        return XDIV_M1[m];
    endfunction

    function automatic logic [3:0] ydiv_m1(input sam_mode_e m);
        return YDIV_M1[m];
    endfunction

endpackage

// File: rtl/sam_edge_det.sv
// Synchronous falling-edge detector: one input register plus a previous-value register.
// The first sample after reset seeds both registers so a level held through reset is not an edge.
module sam_edge_det #(
    parameter logic IDLE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    logic sync_q;
    logic prev_q;
    logic skip_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= IDLE;
            prev_q <= IDLE;
            skip_q <= 1'b1;
        end else begin
            sync_q <= din;
            prev_q <= skip_q ? din : sync_q;
            skip_q <= 1'b0;
        end
    end

    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/sam_vcounter.sv
// SAM VDG video address counter with X/Y dividers per display mode.
// Define SAM_VCOUNTER_DMA_EN to make mode 111 a free-running VClk-driven counter.
module sam_vcounter
    import sam_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic [OFF_W-1:0]  disp_offset,
    input  logic              da0,
    input  logic              hs_n,
    input  logic              fs_n,
    input  logic              vclk_en,
    output logic [ADDR_W-1:0] vid_addr,
    output logic              fetch
);

    logic              da0_fall;
    logic              hs_fall;
    logic              fs_fall;
    logic [ADDR_W-1:0] row_start;
    logic [1:0]        xcnt;
    logic [3:0]        ycnt;
    sam_mode_e         mode_e;
    sam_mode_e         mode_q;
    logic              mode_chg;
    logic [1:0]        x_m1;
    logic [3:0]        y_m1;
    logic [ADDR_W-1:0] preset;

    sam_edge_det #(.IDLE(1'b1)) u_da0 (
        .clk   (clk),
        .reset (reset),
        .din   (da0),
        .fall  (da0_fall)
    );

    sam_edge_det #(.IDLE(1'b1)) u_hs (
        .clk   (clk),
        .reset (reset),
        .din   (hs_n),
        .fall  (hs_fall)
    );

    sam_edge_det #(.IDLE(1'b1)) u_fs (
        .clk   (clk),
        .reset (reset),
        .din   (fs_n),
        .fall  (fs_fall)
    );

    assign mode_e   = sam_mode_e'(mode);
    assign mode_chg = (mode_e != mode_q);
    assign x_m1     = xdiv_m1(mode_e);
    assign y_m1     = ydiv_m1(mode_e);
    assign preset   = {disp_offset, 9'b0};

`ifdef SAM_VCOUNTER_DMA_EN
    logic dma_run;
    assign dma_run = (mode_e == DMA);
`else
    logic unused_vclk_en;
    assign unused_vclk_en = vclk_en;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_addr  <= '0;
            row_start <= '0;
            xcnt      <= '0;
            ycnt      <= '0;
            fetch     <= 1'b0;
            mode_q    <= ALPHA;
        end else begin
            fetch  <= 1'b0;
            mode_q <= mode_e;
            if (fs_fall) begin
                vid_addr  <= preset;
                row_start <= preset;
                xcnt      <= '0;
                ycnt      <= '0;
                fetch     <= 1'b1;
            end else if (mode_chg) begin
                xcnt <= '0;
                ycnt <= '0;
`ifdef SAM_VCOUNTER_DMA_EN
            end else if (dma_run) begin
                if (vclk_en) begin
                    vid_addr <= vid_addr + 16'd1;
                    fetch    <= 1'b1;
                end
`endif
            end else if (hs_fall) begin
                xcnt <= '0;
                if (ycnt >= y_m1) begin
                    ycnt      <= '0;
                    row_start <= vid_addr;
                end else begin
                    ycnt     <= ycnt + 4'd1;
                    vid_addr <= row_start;
                    fetch    <= (vid_addr != row_start);
                end
            end else if (da0_fall) begin
                if (xcnt >= x_m1) begin
                    xcnt     <= '0;
                    vid_addr <= vid_addr + 16'd1;
                    fetch    <= 1'b1;
                end else begin
                    xcnt <= xcnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sam_vcounter.sv
// Scoreboard bench for sam_vcounter with a line/column reference model.
// Define SAM_VCOUNTER_DMA_EN here too when building the DMA variant.
module tb_sam_vcounter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [6:0]  disp_offset = 7'd0;
    logic        da0 = 1'b1;
    logic        hs_n = 1'b1;
    logic        fs_n = 1'b1;
    logic        vclk_en = 1'b0;
    logic [15:0] vid_addr;
    logic        fetch;

    sam_vcounter dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .disp_offset (disp_offset),
        .da0         (da0),
        .hs_n        (hs_n),
        .fs_n        (fs_n),
        .vclk_en     (vclk_en),
        .vid_addr    (vid_addr),
        .fetch       (fetch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fetch = 0;

    // Reference model: address = row base + column offset + bytes fetched this line
    int   m_row, m_col, m_da, m_lines;
    int   m_mode;

    function automatic int xdiv(input int md);
        case (md)
            1: return 3;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int ydiv(input int md);
        case (md)
            0: return 12;
            2: return 3;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit dma_on();
`ifdef SAM_VCOUNTER_DMA_EN
        return m_mode == 7;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] m_addr();
        return 16'(m_row + m_col + m_da / xdiv(m_mode));
    endfunction

    function automatic void push(input logic [15:0] a, input int lat);
        exp_t e;
        e.addr = a;
        e.due  = cyc + lat;
        q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    always @(negedge clk) begin
        if (fetch === 1'b1) begin
            exp_t e;
            n_fetch++;
            n_chk++;
            if (q.size() == 0) begin
                $display("FAIL fetch_unexpected: got addr %h at cyc %0d want none",
                         vid_addr, cyc);
            end else begin
                e = q.pop_front();
                if (vid_addr === e.addr && cyc == e.due) n_pass++;
                else $display("FAIL fetch_addr: got %h@%0d want %h@%0d",
                              vid_addr, cyc, e.addr, e.due);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ev_fs(input logic [6:0] off);
        m_row = int'(off) << 9;
        m_col = 0; m_da = 0; m_lines = 0;
        push(16'(m_row), 2);
        disp_offset = off;
        fs_n = 1'b0; tick(2);
        fs_n = 1'b1; tick(2);
    endtask

    task automatic ev_da();
        if (!dma_on()) begin
            m_da++;
            if (m_da % xdiv(m_mode) == 0) push(m_addr(), 2);
        end
        da0 = 1'b0; tick(2);
        da0 = 1'b1; tick(2);
    endtask

    task automatic ev_hs();
        logic [15:0] cur;
        if (!dma_on()) begin
            cur = m_addr();
            m_lines++;
            if (m_lines >= ydiv(m_mode)) begin
                m_row = int'(cur);
                m_lines = 0;
            end else if (cur != 16'(m_row)) begin
                push(16'(m_row), 2);
            end
            m_col = 0; m_da = 0;
        end
        hs_n = 1'b0; tick(2);
        hs_n = 1'b1; tick(2);
    endtask

    task automatic ev_vclk();
        if (dma_on()) begin
            m_col++;
            push(m_addr(), 1);
        end
        vclk_en = 1'b1; tick(1);
        vclk_en = 1'b0; tick(3);
    endtask

    task automatic set_mode(input int md);
        if (md != m_mode) begin
            m_col = int'(m_addr()) - m_row;
            m_da = 0; m_lines = 0;
            m_mode = md;
        end
        mode = 3'(md);
        tick(2);
    endtask

    initial begin
        m_row = 0; m_col = 0; m_da = 0; m_lines = 0; m_mode = 0;
        tick(3);
        chk("reset_addr", vid_addr, 16'h0000);
        chk("reset_fetch", {15'd0, fetch}, 16'h0000);
        reset = 1'b0;
        tick(3);

        // mode 000: 32 bytes per line, each row repeated 12 times
        ev_fs(7'h02);
        chk("a0_preset", vid_addr, 16'h0400);
        for (int l = 0; l < 12; l++) begin
            for (int i = 0; i < 32; i++) ev_da();
            if (l == 0) chk("a0_line_end", vid_addr, 16'h0420);
            ev_hs();
            if (l == 0) chk("a0_repeat", vid_addr, 16'h0400);
        end
        chk("a0_next_row", vid_addr, 16'h0420);
        ev_da();
        chk("a0_next_byte", vid_addr, 16'h0421);

        // mode 001: Xdiv 3
        set_mode(1);
        ev_fs(7'h00);
        begin
            int f0;
            f0 = n_fetch - 1;
            for (int i = 0; i < 9; i++) ev_da();
            chk("g1c_addr", vid_addr, 16'h0003);
            chk("g1c_fetches", 16'(n_fetch - f0), 16'd4);
        end

        // 16-bit wraparound
        set_mode(5);
        ev_fs(7'h7f);
        for (int i = 0; i < 511; i++) ev_da();
        chk("wrap_top", vid_addr, 16'hffff);
        ev_da();
        chk("wrap_zero", vid_addr, 16'h0000);
        ev_da();
        chk("wrap_next", vid_addr, 16'h0001);

        // simultaneous fs/hs/da0: preset wins
        set_mode(0);
        ev_fs(7'h05);
        for (int i = 0; i < 4; i++) ev_da();
        m_row = 7'h11 << 9; m_col = 0; m_da = 0; m_lines = 0;
        push(16'h2200, 2);
        disp_offset = 7'h11;
        fs_n = 1'b0; hs_n = 1'b0; da0 = 1'b0; tick(2);
        fs_n = 1'b1; hs_n = 1'b1; da0 = 1'b1; tick(2);
        chk("prio_preset", vid_addr, 16'h2200);
        ev_hs();
        chk("prio_ycnt", vid_addr, 16'h2200);

        // reset mid-line in mode 010, da0 held low through reset
        set_mode(2);
        ev_fs(7'h03);
        for (int i = 0; i < 5; i++) ev_da();
        reset = 1'b1; da0 = 1'b0;
        m_row = 0; m_col = 0; m_da = 0; m_lines = 0;
        tick(1);
        chk("rst_mid_addr", vid_addr, 16'h0000);
        chk("rst_mid_fetch", {15'd0, fetch}, 16'h0000);
        reset = 1'b0;
        tick(3);
        da0 = 1'b1; tick(2);
        chk("rst_no_edge", vid_addr, 16'h0000);
        ev_fs(7'h04);
        chk("rst_preset", vid_addr, 16'h0800);

        // mode 111: VClk-driven in DMA builds, Xdiv 1 otherwise
        set_mode(7);
        ev_fs(7'h08);
        for (int i = 0; i < 5; i++) begin
            ev_vclk();
            ev_da();
        end
        chk("dma_adv5", vid_addr, 16'h1005);

        // randomized traffic against the model
        set_mode(0);
        ev_fs(7'h10);
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(99);
            if (r < 60) begin
                if ($urandom_range(9) == 0) disp_offset = 7'($urandom);
                ev_da();
            end else if (r < 80) ev_hs();
            else if (r < 85) ev_fs(7'($urandom));
            else if (r < 92) ev_vclk();
            else set_mode($urandom_range(7));
            chk("rand_addr", vid_addr, m_addr());
        end

        tick(4);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
